imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the decode path. It accepts a fetched instruction and its PC over a valid/ready handshake, classifies the instruction format, and produces the sign- or zero-extended immediate at XLEN width. A two-entry skid buffer gives full throughput with registered backpressure. A synchronous flush input drops in-flight entries on a redirect.

---
 rtl/imm_gen_stage.sv | 163 ++++++++++++++++
 tb/tb_imm_gen_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Decode-path immediate generator: classifies the instruction format, builds the
// XLEN-wide immediate and registers it behind a two-entry main/skid buffer.
module imm_gen_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("imm_gen_stage: XLEN must be 32 or 64");
      end
   endgenerate

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   logic [6:0]      opcode;
   logic [31:0]     imm32;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;
   entry_t          entry_in;

   entry_t main_q, main_d, skid_q, skid_d;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   accept, drain;

   // Every immediate is first formed as a 32-bit signed value, then widened to XLEN.
   always_comb begin
      opcode      = in_inst[6:0];
      imm32       = '0;
      dec_fmt     = FMT_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         7'b0110111, 7'b0010111: begin
            dec_fmt = FMT_U;
            imm32   = {in_inst[31:12], 12'b0};
         end
         7'b1101111: begin
            dec_fmt = FMT_J;
            imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                       in_inst[30:21], 1'b0};
         end
         7'b1100111, 7'b0000011, 7'b0010011: begin
            dec_fmt = FMT_I;
            imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               dec_fmt = FMT_I;
               imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end else begin
               dec_illegal = 1'b1;
            end
         end
         7'b0100011: begin
            dec_fmt = FMT_S;
            imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         7'b1100011: begin
            dec_fmt = FMT_B;
            imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                       in_inst[11:8], 1'b0};
         end
         7'b1110011: begin
            dec_fmt = FMT_Z;
            imm32   = {27'b0, in_inst[19:15]};
         end
         7'b0110011: begin
            dec_fmt = FMT_NONE;
         end
         7'b0111011: begin
            dec_illegal = (XLEN != 64);
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
      dec_imm  = XLEN'($signed(imm32));
      entry_in = {in_inst, in_pc, dec_imm, dec_fmt, dec_illegal};
   end

   assign in_ready = ~skid_valid_q;
   assign accept   = in_valid & in_ready & ~flush;
   assign drain    = main_valid_q & out_ready;

   // A full skid implies in_ready was low, so the skid-to-main move never races an accept.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (drain) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (!main_valid_q || drain) begin
         main_valid_d = accept;
         if (accept) begin
            main_d = entry_in;
         end
      end else if (accept) begin
         skid_d       = entry_in;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

   assign out_valid   = main_valid_q;
   assign out_inst    = main_q.inst;
   assign out_pc      = main_q.pc;
   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: a 32-bit and a 64-bit instance, each with an
// expected-result queue popped by a monitor whenever the output handshakes.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  // 32-bit instance
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_inst, out_pc, out_imm;
  logic [2:0]  out_fmt;
  // 64-bit instance
  logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_ready, v64_out_illegal;
  logic [31:0] v64_in_inst, v64_out_inst;
  logic [63:0] v64_in_pc, v64_out_pc, v64_out_imm;
  logic [2:0]  v64_out_fmt;

  // entry layouts: {inst, pc, imm, fmt, illegal}
  logic [99:0]  exp_q[$];
  logic [163:0] exp64_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int a0, a1, a2, rel;

  logic         held = 1'b0;
  logic [99:0]  snap;

  imm_gen_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(v64_in_valid), .in_ready(v64_in_ready), .in_inst(v64_in_inst), .in_pc(v64_in_pc),
    .out_valid(v64_out_valid), .out_ready(v64_out_ready), .out_inst(v64_out_inst),
    .out_pc(v64_out_pc), .out_imm(v64_out_imm), .out_fmt(v64_out_fmt),
    .out_illegal(v64_out_illegal)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: called at posedge+#1, return at posedge+#1 after the accepting edge
  task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
    int  waited = 0;
    logic acc = 1'b0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready && !flush && !rst;
      if (acc) exp_q.push_back({inst, pc, imm, fmt, ill});
      @(posedge clk); #1;
      if (!acc) begin
        waited++;
        if (waited > 50) begin
          checks++; errors++;
          $display("FAIL send_timeout: inst %h not accepted within 50 cycles", inst);
          break;
        end
      end
    end
    accept_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send64(input logic [31:0] inst, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    int  waited = 0;
    logic acc = 1'b0;
    v64_in_valid = 1'b1; v64_in_inst = inst; v64_in_pc = pc;
    while (!acc) begin
      @(negedge clk);
      acc = v64_in_ready && !flush && !rst;
      if (acc) exp64_q.push_back({inst, pc, imm, fmt, ill});
      @(posedge clk); #1;
      if (!acc) begin
        waited++;
        if (waited > 50) begin
          checks++; errors++;
          $display("FAIL send64_timeout: inst %h not accepted within 50 cycles", inst);
          break;
        end
      end
    end
    v64_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [99:0] e;
    if (!rst && out_valid) begin
      if (held) check("hold_stable", {out_inst, out_pc, out_imm, out_fmt, out_illegal}, snap);
      if (out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: inst %h with empty expected queue", out_inst);
        end else begin
          e = exp_q.pop_front();
          check("out_inst", out_inst, e[99:68]);
          check("out_pc", out_pc, e[67:36]);
          check("out_imm", out_imm, e[35:4]);
          check("out_fmt", out_fmt, e[3:1]);
          check("out_illegal", out_illegal, e[0]);
        end
      end else begin
        held = 1'b1;
        snap = {out_inst, out_pc, out_imm, out_fmt, out_illegal};
      end
    end else begin
      held = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [163:0] e;
    if (!rst && v64_out_valid && v64_out_ready) begin
      if (exp64_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output64: inst %h with empty expected queue", v64_out_inst);
      end else begin
        e = exp64_q.pop_front();
        check("out64_inst", v64_out_inst, e[163:132]);
        check("out64_pc", v64_out_pc, e[131:68]);
        check("out64_imm", v64_out_imm, e[67:4]);
        check("out64_fmt", v64_out_fmt, e[3:1]);
        check("out64_illegal", v64_out_illegal, e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    v64_in_valid = 1'b0; v64_in_inst = '0; v64_in_pc = '0; v64_out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out64_valid", v64_out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // U, J, B at full rate with one-cycle latency
    send(32'h123450B7, 32'h0000_1000, 32'h12345000, 3'd4, 1'b0);
    a0 = accept_cyc;
    check("latency_out_valid", out_valid, 1'b1);
    send(32'hFFDFF06F, 32'h0000_1004, 32'hFFFFFFFC, 3'd5, 1'b0);
    a1 = accept_cyc;
    send(32'hFE000CE3, 32'h0000_1008, 32'hFFFFFFF8, 3'd3, 1'b0);
    a2 = accept_cyc;
    check("throughput_gap1", a1 - a0, 1);
    check("throughput_gap2", a2 - a1, 1);

    // S, Z, unknown opcode, and further formats
    send(32'hFE20AE23, 32'h0000_2000, 32'hFFFFFFFC, 3'd2, 1'b0);
    send(32'h300FD073, 32'h0000_2004, 32'h0000001F, 3'd6, 1'b0);
    send(32'h0000007F, 32'h0000_2008, 32'h00000000, 3'd0, 1'b1);
    send(32'h00500093, 32'h0000_200C, 32'h00000005, 3'd1, 1'b0);
    send(32'h002081B3, 32'h0000_2010, 32'h00000000, 3'd0, 1'b0);
    send(32'h0020803B, 32'h0000_2014, 32'h00000000, 3'd0, 1'b1);
    send(32'hFFF0009B, 32'h0000_2018, 32'h00000000, 3'd0, 1'b1);
    idle(3);
    check("stream_drained", exp_q.size(), 0);

    // 64-bit instance
    send64(32'hFFF0009B, 64'h0000_0001_0000_0000, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    send64(32'h0020803B, 64'h0000_0001_0000_0004, 64'h0, 3'd0, 1'b0);
    send64(32'h800000B7, 64'h0000_0001_0000_0008, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    send64(32'hFFDFF06F, 64'h0000_0001_0000_000C, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);
    idle(3);
    check("stream64_drained", exp64_q.size(), 0);

    // backpressure: two held, third waits for the skid to free
    out_ready = 1'b0;
    send(32'h00100093, 32'h0000_3000, 32'h00000001, 3'd1, 1'b0);
    a0 = accept_cyc;
    send(32'h00200093, 32'h0000_3004, 32'h00000002, 3'd1, 1'b0);
    a1 = accept_cyc;
    check("bp_second_accept_gap", a1 - a0, 1);
    check("bp_in_ready_low", in_ready, 1'b0);
    fork
      send(32'h00300093, 32'h0000_3008, 32'h00000003, 3'd1, 1'b0);
      begin
        idle(3);
        check("bp_in_ready_still_low", in_ready, 1'b0);
        check("bp_main_is_first", out_inst, 32'h00100093);
        rel = cyc;
        out_ready = 1'b1;
      end
    join
    check("bp_third_accept_cycle", accept_cyc - rel, 2);
    idle(3);
    check("bp_drained", exp_q.size(), 0);

    // flush with only main full: same-cycle input dropped
    out_ready = 1'b0;
    send(32'h00400093, 32'h0000_4000, 32'h00000004, 3'd1, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h0000_4004;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_out_valid", out_valid, 1'b0);
    check("flush1_in_ready", in_ready, 1'b1);
    exp_q.delete();
    out_ready = 1'b1;
    send(32'h00600093, 32'h0000_4008, 32'h00000006, 3'd1, 1'b0);
    idle(2);

    // flush with both entries full
    out_ready = 1'b0;
    send(32'h00700093, 32'h0000_5000, 32'h00000007, 3'd1, 1'b0);
    send(32'h00800093, 32'h0000_5004, 32'h00000008, 3'd1, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00900093; in_pc = 32'h0000_5008;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", out_valid, 1'b0);
    check("flush2_in_ready", in_ready, 1'b1);
    exp_q.delete();
    out_ready = 1'b1;
    send(32'h00A00093, 32'h0000_500C, 32'h0000000A, 3'd1, 1'b0);
    idle(2);
    check("flush_drained", exp_q.size(), 0);

    // asynchronous reset mid-stream with a full buffer
    out_ready = 1'b0;
    send(32'h00B00093, 32'h0000_6000, 32'h0000000B, 3'd1, 1'b0);
    send(32'h00C00093, 32'h0000_6004, 32'h0000000C, 3'd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h0000_6008, 32'hFFFFFFFF, 3'd1, 1'b0);
    check("post_rst_latency", out_valid, 1'b1);
    idle(3);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_queue64_empty", exp64_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
